// File: rtl/preg_pkg.sv
// Shared types and sizing for the P10 result register and its unload path.
package preg_pkg;
  localparam int NLIMB   = 130;
  localparam int LIMB_W  = 17;
  localparam int DIG_W   = 16;
  localparam int LANES   = 2;
  localparam int NBEAT   = NLIMB / LANES;
  localparam int BEAT_W  = $clog2(NBEAT);
  localparam int CARRY_W = 2;

  typedef logic [LIMB_W-1:0]  limb_t;
  typedef logic [DIG_W-1:0]   digit_t;
  typedef logic [CARRY_W-1:0] carry_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } unload_state_e;
endpackage

// File: rtl/carry_lane_chain.sv
// Ripples a carry across N_LANES redundant limbs, producing normalized digits and a carry-out.
module carry_lane_chain
  import preg_pkg::*;
#(
  parameter int N_LANES = LANES
) (
  input  logic [N_LANES*LIMB_W-1:0] limbs_i,
  input  carry_t                    carry_i,
  output logic [N_LANES*DIG_W-1:0]  digits_o,
  output carry_t                    carry_o
);

  logic [LIMB_W:0] sum;
  carry_t          c;

  // NOTE: blocking assignments here are intentional; c must ripple lane to lane within one evaluation.
  always_comb begin
    c        = carry_i;
    sum      = '0;
    digits_o = '0;
    for (int j = 0; j < N_LANES; j++) begin
      sum = {1'b0, limbs_i[j*LIMB_W +: LIMB_W]} + {{(LIMB_W-1){1'b0}}, c};
      digits_o[j*DIG_W +: DIG_W] = sum[DIG_W-1:0];
      c = sum[LIMB_W:DIG_W];
    end
    carry_o = c;
  end

endmodule

// File: rtl/preg_unload.sv
// Snapshots the redundant P10 limbs and streams carry-resolved 16-bit digits, LSB first.
module preg_unload
  import preg_pkg::*;
(
  input  logic                    clk_sq,
  input  logic                    reset_sq,
  input  logic                    start,
  input  logic [NLIMB*LIMB_W-1:0] in_limbs,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DIG_W-1:0]  out_data,
  output logic                    out_last,
  output logic [1:0]              out_carry,
  output logic                    done
);

  localparam int IDX_W = $clog2(NLIMB);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEAT - 1);

  unload_state_e state_q;
  logic [BEAT_W-1:0]        beat_q;
  logic [BEAT_W-1:0]        load_beat;
  carry_t                   carry_q;
  carry_t                   chain_cin;
  carry_t                   chain_cout;
  logic [LANES*LIMB_W-1:0]  chain_limbs;
  logic [LANES*DIG_W-1:0]   chain_digits;
  limb_t                    snap_q [NLIMB];

  logic                     busy_q;
  logic                     out_valid_q;
  logic                     out_last_q;
  logic [LANES*DIG_W-1:0]   out_data_q;
  carry_t                   out_carry_q;
  logic                     done_q;

  logic capture;
  logic accept;
  logic at_last;
  logic load_is_last;

  assign capture      = (state_q == IDLE) && start;
  assign accept       = out_valid_q && out_ready;
  assign at_last      = (beat_q == LAST_BEAT);
  assign load_is_last = (load_beat == LAST_BEAT);

  // The chain always computes the beat that will be loaded next: beat 0 straight from
  // in_limbs at capture (snapshot not yet written), otherwise the successor of beat_q.
  always_comb begin
    load_beat = '0;
    if (state_q != IDLE) begin
      load_beat = at_last ? beat_q : beat_q + 1'b1;
    end
  end

  always_comb begin
    chain_cin   = (state_q == IDLE) ? '0 : carry_q;
    chain_limbs = '0;
    for (int j = 0; j < LANES; j++) begin
      if (state_q == IDLE) begin
        chain_limbs[j*LIMB_W +: LIMB_W] = in_limbs[j*LIMB_W +: LIMB_W];
      end else begin
        chain_limbs[j*LIMB_W +: LIMB_W] =
          snap_q[IDX_W'(load_beat) * IDX_W'(LANES) + IDX_W'(j)];
      end
    end
  end

  carry_lane_chain #(.N_LANES(LANES)) u_chain (
    .limbs_i  (chain_limbs),
    .carry_i  (chain_cin),
    .digits_o (chain_digits),
    .carry_o  (chain_cout)
  );

  // NOTE: the snapshot is a plain data array with no reset; it is only read after a capture writes it.
  always_ff @(posedge clk_sq) begin
    if (capture) begin
      for (int k = 0; k < NLIMB; k++) begin
        snap_q[k] <= in_limbs[k*LIMB_W +: LIMB_W];
      end
    end
  end

  // carry_q holds the carry out of the beat currently on out_data, i.e. the carry into the next one.
  always_ff @(posedge clk_sq or negedge reset_sq) begin
    if (!reset_sq) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      carry_q     <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_carry_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= STREAM;
            beat_q      <= '0;
            carry_q     <= chain_cout;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b1;
            out_data_q  <= chain_digits;
            out_last_q  <= load_is_last;
            out_carry_q <= load_is_last ? chain_cout : '0;
          end
        end
        STREAM: begin
          if (accept) begin
            if (at_last) begin
              state_q     <= DONE;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_carry_q <= '0;
              done_q      <= 1'b1;
            end else begin
              beat_q      <= load_beat;
              carry_q     <= chain_cout;
              out_data_q  <= chain_digits;
              out_last_q  <= load_is_last;
              out_carry_q <= load_is_last ? chain_cout : '0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_carry = out_carry_q;
  assign done      = done_q;

endmodule

// File: tb/tb_preg_unload.sv
// Directed bench for preg_unload: big-integer reference model feeding a beat scoreboard.
module tb_preg_unload;
  import preg_pkg::*;

  localparam int VW = NLIMB * LIMB_W;
  localparam int OW = LANES * DIG_W;

  typedef logic [VW-1:0] vec_t;

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
    logic [1:0]    carry;
  } beat_t;

  logic          clk_sq = 1'b0;
  logic          reset_sq;
  logic          start;
  vec_t          in_limbs;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic [1:0]    out_carry;
  logic          done;

  int    errors   = 0;
  int    checks   = 0;
  int    beat_cnt = 0;
  beat_t sb [$];
  beat_t exp_beat;
  logic          stall_prev = 1'b0;
  logic [OW-1:0] held_data;
  logic          held_last;
  logic [1:0]    held_carry;

  preg_unload dut (
    .clk_sq    (clk_sq),
    .reset_sq  (reset_sq),
    .start     (start),
    .in_limbs  (in_limbs),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_carry (out_carry),
    .done      (done)
  );

  always #5 clk_sq = ~clk_sq;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: add every limb at weight 2^(16k) into an integer array, then normalize once.
  task automatic push_expected(input vec_t v);
    int    acc [NLIMB+2];
    beat_t e;
    for (int i = 0; i < NLIMB + 2; i++) acc[i] = 0;
    for (int k = 0; k < NLIMB; k++) acc[k] = int'(v[k*LIMB_W +: LIMB_W]);
    for (int i = 0; i < NLIMB; i++) begin
      acc[i+1] = acc[i+1] + (acc[i] >> DIG_W);
      acc[i]   = acc[i] & 32'hFFFF;
    end
    for (int b = 0; b < NBEAT; b++) begin
      for (int j = 0; j < LANES; j++) e.data[j*DIG_W +: DIG_W] = acc[b*LANES+j][DIG_W-1:0];
      e.last  = (b == NBEAT - 1);
      e.carry = (b == NBEAT - 1) ? acc[NLIMB][1:0] : 2'd0;
      sb.push_back(e);
    end
  endtask

  function automatic vec_t fill(input logic [LIMB_W-1:0] val);
    vec_t v;
    for (int k = 0; k < NLIMB; k++) v[k*LIMB_W +: LIMB_W] = val;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < NLIMB; k++) v[k*LIMB_W +: LIMB_W] = LIMB_W'($urandom);
    return v;
  endfunction

  // Monitor: outputs frozen under backpressure, and every accepted beat matches the scoreboard.
  always @(negedge clk_sq) begin
    if (reset_sq && out_valid) begin
      if (stall_prev) begin
        check("stall_data", 64'(out_data), 64'(held_data));
        check("stall_last", 64'(out_last), 64'(held_last));
        check("stall_carry", 64'(out_carry), 64'(held_carry));
      end
      if (out_ready) begin
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_beat = sb.pop_front();
          check("beat_data", 64'(out_data), 64'(exp_beat.data));
          check("beat_last", 64'(out_last), 64'(exp_beat.last));
          check("beat_carry", 64'(out_carry), 64'(exp_beat.carry));
        end
        beat_cnt <= beat_cnt + 1;
      end
      stall_prev <= !out_ready;
      held_data  <= out_data;
      held_last  <= out_last;
      held_carry <= out_carry;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  task automatic run_stream(input vec_t v, input bit rand_ready, input int restart_at,
                            input vec_t v2, input int reset_at, input bit chk_first,
                            input logic [OW-1:0] first_exp, input int exp_cycles);
    int n;
    bit seen;
    bit restarted;
    n = 0;
    seen = 0;
    restarted = 0;
    beat_cnt = 0;
    push_expected(v);
    in_limbs = v;
    start = 1'b1;
    while (n < 1000 && !seen) begin
      @(posedge clk_sq);
      #1;
      n++;
      start = 1'b0;
      if (n == 1) begin
        check("busy_after_start", 64'(busy), 64'd1);
        check("valid_latency1", 64'(out_valid), 64'd1);
        if (chk_first) check("first_beat", 64'(out_data), 64'(first_exp));
      end
      if (restart_at >= 0 && !restarted && beat_cnt == restart_at) begin
        in_limbs = v2;
        start = 1'b1;
        restarted = 1;
      end
      if (reset_at >= 0 && beat_cnt == reset_at) begin
        reset_sq = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk_sq);
        #1;
        reset_sq = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(posedge clk_sq);
          #1;
          check("rst_no_done", 64'(done), 64'd0);
        end
        return;
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) seen = 1;
    end
    check("done_seen", 64'(seen), 64'd1);
    if (exp_cycles > 0) check("done_latency", 64'(n), 64'(exp_cycles));
    check("busy_at_done", 64'(busy), 64'd0);
    check("beat_count", 64'(beat_cnt), 64'(NBEAT));
    check("sb_drained", 64'(sb.size()), 64'd0);
    @(posedge clk_sq);
    #1;
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    vec_t v;
    reset_sq  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    in_limbs  = '0;
    repeat (3) @(posedge clk_sq);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_last", 64'(out_last), 64'd0);
    check("reset_carry", 64'(out_carry), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_data", 64'(out_data), 64'd0);
    reset_sq = 1'b1;
    @(posedge clk_sq);
    #1;

    // All limbs 1, full rate: start cycle + 65 beats, done in the 67th cycle (66 edges after start).
    out_ready = 1'b1;
    run_stream(fill(17'h00001), 0, -1, '0, -1, 1, 32'h0001_0001, 66);

    // Carry out of lane 0 lands in lane 1.
    v = '0;
    v[LIMB_W-1:0] = 17'h1FFFF;
    run_stream(v, 0, -1, '0, -1, 1, 32'h0001_FFFF, 66);

    // Worst-case limbs with random backpressure.
    run_stream(fill(17'h1FFFF), 1, -1, '0, -1, 1, 32'h0000_FFFF, 0);

    // Random limbs, random backpressure.
    run_stream(rand_vec(), 1, -1, '0, -1, 0, '0, 0);

    // A second start at beat 10 must not disturb the stream.
    run_stream(rand_vec(), 1, 10, rand_vec(), -1, 0, '0, 0);

    // Reset at beat 30, then a fresh snapshot streams cleanly.
    run_stream(rand_vec(), 0, -1, '0, 30, 0, '0, 0);
    run_stream(rand_vec(), 1, -1, '0, -1, 0, '0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
